flag_xfer_arbiter: RTL and testbench

- Shares one toggle-based flag/ack clock-domain crossing among N requesters, all in the clkA domain.
- Grants requesters round-robin and latches the winner's ID and payload into a holding register.
- Issues a single-cycle launch on the crossing's flag input, then waits for the crossing's busy indication to clear before reporting completion to the winner.
- The held payload stays stable for the whole crossing window, so the clkB side can sample it when its flag-out pulse fires.

---
 rtl/flag_xfer_arbiter_pkg.sv | 18 +
 rtl/flag_xfer_arbiter_if.sv | 33 +++
 rtl/flag_xfer_arbiter_rr_arbiter.sv | 42 ++++
 rtl/flag_xfer_arbiter.sv | 150 +++++++++++++++
 tb/tb_flag_xfer_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flag_xfer_arbiter_pkg.sv
// Shared types and default sizing for the flag/ack crossing arbiter.
package flag_xfer_pkg;

  // Arbiter FSM states, one per phase of a crossing transaction.
  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitHi,
    StWaitLo,
    StDone
  } xfer_state_e;

  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefDw      = 8;
  localparam int unsigned DefTimeout = 64;
  localparam int unsigned DefCntw    = 16;

endpackage

// File: rtl/flag_xfer_arbiter_if.sv
// Bundle of requester-side and crossing-side signals around the arbiter.
// master: requesters plus the crossing (drive req/req_data/xing_busy).
// slave:  the arbiter itself.
interface flag_xfer_arbiter_if
  import flag_xfer_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned DW   = DefDw,
  parameter int unsigned CNTW = DefCntw
) ();

  logic [NREQ-1:0]         req;
  logic [NREQ*DW-1:0]      req_data;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         done;
  logic [DW-1:0]           xfer_data;
  logic [$clog2(NREQ)-1:0] xfer_id;
  logic                    flag_in;
  logic                    xing_busy;
  logic                    err_timeout;
  logic [CNTW-1:0]         xfer_count;

  modport master (
    output req, req_data, xing_busy,
    input  grant, done, xfer_data, xfer_id, flag_in, err_timeout, xfer_count
  );

  modport slave (
    input  req, req_data, xing_busy,
    output grant, done, xfer_data, xfer_id, flag_in, err_timeout, xfer_count
  );

endinterface

// File: rtl/flag_xfer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter
  import flag_xfer_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int unsigned IW  = $clog2(NREQ);
  localparam int unsigned IW1 = IW + 1;

  logic           w_found;
  logic [IW:0]    w_sum;
  logic [IW-1:0]  w_pos;

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr and k are both below NREQ, so one conditional subtract is a full modulo.
      w_sum = {1'b0, i_ptr} + IW1'(k);
      if (w_sum >= IW1'(NREQ)) begin
        w_sum = w_sum - IW1'(NREQ);
      end
      w_pos = w_sum[IW-1:0];
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/flag_xfer_arbiter.sv
// Shares one toggle flag/ack crossing among NREQ requesters; holds the winner's
// id and payload stable across the whole crossing window.
module flag_xfer_arbiter
  import flag_xfer_pkg::*;
#(
  parameter int unsigned NREQ    = DefNreq,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned CNTW    = DefCntw
) (
  input  logic                      clkA,
  input  logic                      rstA,
  flag_xfer_arbiter_if.slave        io_bus
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  xfer_state_e     r_state,     w_state_nxt;
  logic [NREQ-1:0] r_grant,     w_grant_nxt;
  logic [NREQ-1:0] r_done,      w_done_nxt;
  logic [DW-1:0]   r_xfer_data, w_xfer_data_nxt;
  logic [IW-1:0]   r_xfer_id,   w_xfer_id_nxt;
  logic            r_flag_in,   w_flag_in_nxt;
  logic            r_err,       w_err_nxt;
  logic [CNTW-1:0] r_count,     w_count_nxt;
  logic [IW-1:0]   r_ptr,       w_ptr_nxt;
  logic [TW-1:0]   r_tcnt,      w_tcnt_nxt;

  logic [NREQ-1:0] w_win_onehot;
  logic [IW-1:0]   w_win_idx;
  logic [DW-1:0]   w_win_data;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .i_req   (io_bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_win_onehot),
    .o_idx   (w_win_idx)
  );

  // Select the winning requester's payload slice.
  always_comb begin
    w_win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win_idx == IW'(i)) begin
        w_win_data = io_bus.req_data[i*DW +: DW];
      end
    end
  end

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_done_nxt      = '0;
    w_xfer_data_nxt = r_xfer_data;
    w_xfer_id_nxt   = r_xfer_id;
    w_flag_in_nxt   = 1'b0;
    w_err_nxt       = r_err;
    w_count_nxt     = r_count;
    w_ptr_nxt       = r_ptr;
    w_tcnt_nxt      = r_tcnt;

    case (r_state)
      StIdle: begin
        if (|io_bus.req) begin
          w_grant_nxt     = w_win_onehot;
          w_xfer_id_nxt   = w_win_idx;
          w_xfer_data_nxt = w_win_data;
          w_state_nxt     = StLaunch;
        end
      end
      StLaunch: begin
        // A stale busy from the previous transfer must clear before toggling again.
        if (!io_bus.xing_busy) begin
          w_flag_in_nxt = 1'b1;
          w_state_nxt   = StWaitHi;
        end
      end
      StWaitHi: begin
        // Do not mistake the low before busy rises for completion.
        if (io_bus.xing_busy) begin
          w_tcnt_nxt  = '0;
          w_state_nxt = StWaitLo;
        end
      end
      StWaitLo: begin
        // Saturating count; timeout only flags, since a launched toggle cannot be recalled.
        if (r_tcnt < TW'(TIMEOUT)) begin
          w_tcnt_nxt = r_tcnt + TW'(1);
          if (r_tcnt + TW'(1) == TW'(TIMEOUT)) begin
            w_err_nxt = 1'b1;
          end
        end
        if (!io_bus.xing_busy) begin
          w_done_nxt            = '0;
          w_done_nxt[r_xfer_id] = 1'b1;
          w_grant_nxt           = '0;
          w_count_nxt           = r_count + CNTW'(1);
          w_ptr_nxt             = (r_xfer_id == IW'(NREQ - 1)) ? '0 : r_xfer_id + IW'(1);
          w_state_nxt           = StDone;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clkA or posedge rstA) begin
    if (rstA) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_done      <= '0;
      r_xfer_data <= '0;
      r_xfer_id   <= '0;
      r_flag_in   <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
      r_ptr       <= '0;
      r_tcnt      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_xfer_data <= w_xfer_data_nxt;
      r_xfer_id   <= w_xfer_id_nxt;
      r_flag_in   <= w_flag_in_nxt;
      r_err       <= w_err_nxt;
      r_count     <= w_count_nxt;
      r_ptr       <= w_ptr_nxt;
      r_tcnt      <= w_tcnt_nxt;
    end
  end

  assign io_bus.grant       = r_grant;
  assign io_bus.done        = r_done;
  assign io_bus.xfer_data   = r_xfer_data;
  assign io_bus.xfer_id     = r_xfer_id;
  assign io_bus.flag_in     = r_flag_in;
  assign io_bus.err_timeout = r_err;
  assign io_bus.xfer_count  = r_count;

endmodule

// File: tb/tb_flag_xfer_arbiter.sv
// Directed bench for flag_xfer_arbiter with a crossing busy model and a
// scoreboard of expected (id, payload) completions.
module tb_flag_xfer_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 64;
  localparam int CNTW    = 3;

  logic clkA = 1'b0;
  logic rstA = 1'b1;
  always #5 clkA = ~clkA;

  flag_xfer_arbiter_if #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) bus ();

  flag_xfer_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (TIMEOUT),
    .CNTW    (CNTW)
  ) dut (
    .clkA   (clkA),
    .rstA   (rstA),
    .io_bus (bus)
  );

  // Crossing model: busy rises the cycle after flag_in, stays high busy_len cycles.
  logic m_busy   = 1'b0;
  logic f_busy   = 1'b0;
  int   busy_len = 6;
  int   busy_cnt = 0;
  bit   arm      = 1'b0;
  assign bus.xing_busy = m_busy | f_busy;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  int              n_tests   = 0;
  int              n_fail    = 0;
  int              done_seen = 0;
  int              flag_seen = 0;
  logic [CNTW-1:0] exp_cnt   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clkA) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) m_busy = 1'b0;
    end
    if (bus.flag_in === 1'b1) arm = 1'b1;
    else if (arm) begin
      arm      = 1'b0;
      m_busy   = 1'b1;
      busy_cnt = busy_len;
    end
  end

  // Monitor: grant never multi-hot; on each done pop the scoreboard.
  always @(negedge clkA) begin
    if (!rstA) begin
      check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      if (bus.flag_in === 1'b1) flag_seen++;
      if (bus.done !== '0) begin
        done_seen++;
        exp_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done_onehot", 32'(bus.done), 32'd1 << mon_e.id);
          check("xfer_id", 32'(bus.xfer_id), 32'(mon_e.id));
          check("xfer_data", 32'(bus.xfer_data), 32'(mon_e.data));
        end
        check("flag_pulses", flag_seen, 1);
        flag_seen = 0;
        check("xfer_count", 32'(bus.xfer_count), 32'(exp_cnt));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_flag"}, 32'(bus.flag_in), 32'd0);
    check({tag, "_data"}, 32'(bus.xfer_data), 32'd0);
    check({tag, "_id"}, 32'(bus.xfer_id), 32'd0);
    check({tag, "_err"}, 32'(bus.err_timeout), 32'd0);
    check({tag, "_count"}, 32'(bus.xfer_count), 32'd0);
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int base = done_seen;
    int c    = 0;
    while ((done_seen - base) < n && c < budget) begin
      @(negedge clkA);
      c++;
    end
    check(tag, done_seen - base, n);
  endtask

  task automatic wait_grant(input int idx, input int budget, input string tag);
    int c = 0;
    while (bus.grant[idx] !== 1'b1 && c < budget) begin
      @(negedge clkA);
      c++;
    end
    check(tag, 32'(bus.grant), 32'd1 << idx);
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int c = 0;
    while (m_busy !== 1'b1 && c < budget) begin
      @(negedge clkA);
      c++;
    end
    check(tag, 32'(m_busy), 32'd1);
  endtask

  // Reset DUT and the bench-side models together.
  task automatic do_reset();
    @(negedge clkA);
    rstA = 1'b1;
    #1;
    m_busy    = 1'b0;
    busy_cnt  = 0;
    arm       = 1'b0;
    flag_seen = 0;
    exp_cnt   = '0;
    sb.delete();
    check_reset("rst_async");
    @(negedge clkA);
    rstA = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    rstA         = 1'b1;
    repeat (3) @(negedge clkA);
    check_reset("rst_init");
    rstA = 1'b0;

    // Single request from requester 0.
    bus.req_data[7:0] = 8'hA5;
    sb.push_back('{id: 2'd0, data: 8'hA5});
    bus.req = 4'b0001;
    wait_dones(1, 40, "t1_done");
    bus.req = '0;
    check("t1_count", 32'(bus.xfer_count), 32'd1);

    // All four held from pointer 0: order 0,1,2,3,0.
    do_reset();
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    sb.push_back('{id: 2'd0, data: 8'h11});
    sb.push_back('{id: 2'd1, data: 8'h22});
    sb.push_back('{id: 2'd2, data: 8'h33});
    sb.push_back('{id: 2'd3, data: 8'h44});
    sb.push_back('{id: 2'd0, data: 8'h11});
    bus.req = 4'b1111;
    wait_dones(5, 150, "t2_dones");
    bus.req = '0;
    check("t2_count", 32'(bus.xfer_count), 32'd5);

    // Serve 2 (pointer becomes 3), then 1001: 3 first, then wrap to 0.
    sb.push_back('{id: 2'd2, data: 8'h33});
    bus.req = 4'b0100;
    wait_dones(1, 40, "t3_pre");
    bus.req = '0;
    sb.push_back('{id: 2'd3, data: 8'h44});
    sb.push_back('{id: 2'd0, data: 8'h11});
    bus.req = 4'b1001;
    wait_grant(3, 20, "t3_grant3");
    bus.req[3] = 1'b0;  // dropping req while owning has no effect
    wait_dones(2, 80, "t3_dones");
    bus.req = '0;
    check("t3_count_wrap", 32'(bus.xfer_count), 32'd0);

    // Stale busy at LAUNCH: no flag until busy drops.
    f_busy = 1'b1;
    bus.req_data[23:16] = 8'h5A;
    sb.push_back('{id: 2'd2, data: 8'h5A});
    bus.req = 4'b0100;
    wait_grant(2, 20, "t4_grant");
    repeat (5) @(negedge clkA);
    check("t4_no_flag", flag_seen, 0);
    check("t4_held", 32'(bus.grant), 32'h4);
    f_busy = 1'b0;
    wait_dones(1, 40, "t4_done");
    bus.req = '0;

    // Stuck busy for 100 cycles: timeout flags but transfer still completes.
    busy_len = 100;
    sb.push_back('{id: 2'd1, data: 8'h22});
    bus.req = 4'b0010;
    wait_busy(20, "t5_busy");
    repeat (40) @(negedge clkA);
    check("t5_err_early", 32'(bus.err_timeout), 32'd0);
    check("t5_id_held", 32'(bus.xfer_id), 32'd1);
    repeat (40) @(negedge clkA);
    check("t5_err_set", 32'(bus.err_timeout), 32'd1);
    check("t5_no_abort", 32'(bus.grant), 32'h2);
    wait_dones(1, 60, "t5_done");
    bus.req = '0;
    repeat (3) @(negedge clkA);
    check("t5_err_sticky", 32'(bus.err_timeout), 32'd1);
    busy_len = 6;

    // Reset during WAIT_LO, then a fresh request completes normally.
    bus.req_data[7:0] = 8'h3C;
    sb.push_back('{id: 2'd0, data: 8'h3C});
    bus.req = 4'b0001;
    wait_busy(20, "t6_busy");
    repeat (2) @(negedge clkA);
    bus.req = '0;
    do_reset();
    bus.req_data[15:8] = 8'h77;
    sb.push_back('{id: 2'd1, data: 8'h77});
    bus.req = 4'b0010;
    wait_dones(1, 40, "t6_done");
    bus.req = '0;
    check("t6_count", 32'(bus.xfer_count), 32'd1);
    check("t6_err_clear", 32'(bus.err_timeout), 32'd0);

    repeat (3) @(negedge clkA);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
